// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared instruction/data memory.
// Port 0 is the CPU datapath and port 1 is the DMA/program loader. A
// three-state FSM hands ownership between them, and a burst limit keeps
// either port from starving the other. The memory address, write data and
// write enable are taken from whichever port currently owns the memory.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter int CPU_PRIORITY = 1
) (
  input  logic              clock,
  input  logic              resetN,
  // CPU port
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic              cpuGnt,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuRValid,
  output logic              cpuStall,
  // DMA port
  input  logic              dmaReq,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] dmaWData,
  output logic              dmaGnt,
  output logic [DATA_W-1:0] dmaRData,
  output logic              dmaRValid,
  // memory side
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWE,
  input  logic [DATA_W-1:0] memRData
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  burst_q, burst_d, burst_inc;
  logic              cpu_gnt_q, dma_gnt_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              cpu_rvalid_q, dma_rvalid_q;
  logic              cpu_xfer, dma_xfer;

  // A transfer is a cycle in which the owner is also requesting.
  assign cpu_xfer = cpu_gnt_q & cpuReq;
  assign dma_xfer = dma_gnt_q & dmaReq;

  // The owner drives the memory; IDLE parks the bus at zero. The write
  // enable is also gated by reset so no write lands in a reset cycle.
  always_comb begin
    memAddr  = '0;
    memWData = '0;
    if (cpu_gnt_q) begin
      memAddr  = cpuAddr;
      memWData = cpuWData;
    end else if (dma_gnt_q) begin
      memAddr  = dmaAddr;
      memWData = dmaWData;
    end
  end

  assign memWE = resetN & ((cpu_xfer & cpuWe) | (dma_xfer & dmaWe));

  // Next-state and burst-count logic; the count restarts on every ownership change.
  always_comb begin
    state_d   = state_q;
    burst_inc = (burst_q == MAX_CNT) ? MAX_CNT : burst_q + 1'b1;
    burst_d   = burst_q;
    case (state_q)
      IDLE: begin
        if (cpuReq && (!dmaReq || (CPU_PRIORITY != 0))) state_d = OWN_CPU;
        else if (dmaReq)                                state_d = OWN_DMA;
      end
      OWN_CPU: begin
        if (!cpuReq) begin
          state_d = dmaReq ? OWN_DMA : IDLE;
        end else begin
          burst_d = burst_inc;
          if ((burst_inc == MAX_CNT) && dmaReq) state_d = OWN_DMA;
        end
      end
      OWN_DMA: begin
        if (!dmaReq) begin
          state_d = cpuReq ? OWN_CPU : IDLE;
        end else begin
          burst_d = burst_inc;
          if ((burst_inc == MAX_CNT) && cpuReq) state_d = OWN_CPU;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) burst_d = '0;
  end

  // FSM state, registered grants and read-data capture for both ports.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q      <= IDLE;
      burst_q      <= '0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      cpu_gnt_q    <= (state_d == OWN_CPU);
      dma_gnt_q    <= (state_d == OWN_DMA);
      cpu_rvalid_q <= cpu_xfer & ~cpuWe;
      dma_rvalid_q <= dma_xfer & ~dmaWe;
      if (cpu_xfer && !cpuWe) cpu_rdata_q <= memRData;
      if (dma_xfer && !dmaWe) dma_rdata_q <= memRData;
    end
  end

  assign cpuGnt    = cpu_gnt_q;
  assign dmaGnt    = dma_gnt_q;
  assign cpuRData  = cpu_rdata_q;
  assign dmaRData  = dma_rdata_q;
  assign cpuRValid = cpu_rvalid_q;
  assign dmaRValid = dma_rvalid_q;
  assign cpuStall  = cpuReq & ~cpu_gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory.
module tb_mem_port_arbiter;

  logic        clock;
  logic        resetN;
  logic        cpuReq, cpuWe, cpuGnt, cpuRValid, cpuStall;
  logic [31:0] cpuAddr, cpuWData, cpuRData;
  logic        dmaReq, dmaWe, dmaGnt, dmaRValid;
  logic [31:0] dmaAddr, dmaWData, dmaRData;
  logic [31:0] memAddr, memWData, memRData;
  logic        memWE;

  int n_checks = 0;
  int n_errors = 0;

  // backing memory: 256 words, with a bench-side preload port
  logic [31:0] mem [0:255];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .CPU_PRIORITY(1)
  ) dut (
    .clock(clock), .resetN(resetN),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuGnt(cpuGnt), .cpuRData(cpuRData), .cpuRValid(cpuRValid), .cpuStall(cpuStall),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
    .dmaGnt(dmaGnt), .dmaRData(dmaRData), .dmaRValid(dmaRValid),
    .memAddr(memAddr), .memWData(memWData), .memWE(memWE), .memRData(memRData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign memRData = mem[memAddr[9:2]];

  always @(posedge clock) begin
    if (ld_en)      mem[ld_idx] <= ld_data;
    else if (memWE) mem[memAddr[9:2]] <= memWData;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_idx  = addr[9:2];
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // expected {cpuGnt, dmaGnt} per cycle with both ports requesting from IDLE
  logic [1:0] exp_gnt [0:12];

  initial begin
    exp_gnt = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b01, 2'b01, 2'b01, 2'b01,
                2'b10, 2'b10, 2'b10, 2'b10};
    resetN = 1'b0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
    dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = '0; dmaWData = '0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    #1;
    tick();
    preload(32'h40,  32'hDEADBEEF);
    preload(32'h80,  32'hCAFEF00D);
    preload(32'h100, 32'h0);
    preload(32'h200, 32'h0);
    preload(32'h204, 32'hAAAA5555);

    // 1. reset held with both ports requesting writes
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h40;
    dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_gnt",    {62'd0, cpuGnt, dmaGnt}, 64'd0);
      check_val("rst_rvalid", {62'd0, cpuRValid, dmaRValid}, 64'd0);
      check_val("rst_we",     {63'd0, memWE}, 64'd0);
    end
    cpuReq = 1'b0; cpuWe = 1'b0; dmaReq = 1'b0; dmaWe = 1'b0;
    resetN = 1'b1;
    tick();
    check_val("idle_gnt",  {62'd0, cpuGnt, dmaGnt}, 64'd0);
    check_val("idle_addr", {32'd0, memAddr}, 64'd0);

    // 2. CPU read alone of 0x40
    cpuReq = 1'b1; cpuAddr = 32'h40; #1;
    check_val("rd_c0_stall", {63'd0, cpuStall}, 64'd1);
    check_val("rd_c0_gnt",   {63'd0, cpuGnt}, 64'd0);
    tick();
    check_val("rd_c1_gnt",   {63'd0, cpuGnt}, 64'd1);
    check_val("rd_c1_stall", {63'd0, cpuStall}, 64'd0);
    check_val("rd_c1_addr",  {32'd0, memAddr}, 64'h40);
    tick();
    cpuReq = 1'b0; #1;
    check_val("rd_c2_valid", {63'd0, cpuRValid}, 64'd1);
    check_val("rd_c2_data",  {32'd0, cpuRData}, 64'hDEADBEEF);
    check_val("rd_c2_stall", {63'd0, cpuStall}, 64'd0);
    tick();
    check_val("rd_c3_valid", {63'd0, cpuRValid}, 64'd0);
    check_val("rd_c3_gnt",   {62'd0, cpuGnt, dmaGnt}, 64'd0);

    // 3. both requesting reads continuously: CPU x4, DMA x4, CPU x4
    cpuAddr = 32'h40; dmaAddr = 32'h80;
    for (int c = 0; c <= 12; c++) begin
      cpuReq = (c < 12); dmaReq = (c < 12); #1;
      check_val($sformatf("burst_c%0d", c), {62'd0, cpuGnt, dmaGnt}, {62'd0, exp_gnt[c]});
      if (c == 6) begin
        check_val("burst_dma_valid", {63'd0, dmaRValid}, 64'd1);
        check_val("burst_dma_data",  {32'd0, dmaRData}, 64'hCAFEF00D);
      end
      tick();
    end
    check_val("burst_end_gnt", {62'd0, cpuGnt, dmaGnt}, 64'd0);

    // 4. DMA write of 0x12345678 to 0x100, then CPU read-back
    dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 32'h100; dmaWData = 32'h12345678; #1;
    check_val("dw_c0_we", {63'd0, memWE}, 64'd0);
    tick();
    check_val("dw_c1_we",   {63'd0, memWE}, 64'd1);
    check_val("dw_c1_addr", {32'd0, memAddr}, 64'h100);
    check_val("dw_c1_data", {32'd0, memWData}, 64'h12345678);
    tick();
    dmaReq = 1'b0; dmaWe = 1'b0; #1;
    check_val("dw_c2_we",    {63'd0, memWE}, 64'd0);
    check_val("dw_c2_valid", {63'd0, dmaRValid}, 64'd0);
    check_val("dw_mem",      {32'd0, mem[8'h40]}, 64'h12345678);
    tick();
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h100;
    tick();
    tick();
    cpuReq = 1'b0; #1;
    check_val("dw_rb_valid", {63'd0, cpuRValid}, 64'd1);
    check_val("dw_rb_data",  {32'd0, cpuRData}, 64'h12345678);
    tick();

    // 5. CPU drops after 2 transfers while DMA waits: direct handover
    cpuReq = 1'b1; cpuAddr = 32'h40;
    tick();
    dmaReq = 1'b1; dmaAddr = 32'h80; #1;
    check_val("ho_c1_gnt", {62'd0, cpuGnt, dmaGnt}, 64'h2);
    tick();
    check_val("ho_c2_gnt",   {62'd0, cpuGnt, dmaGnt}, 64'h2);
    check_val("ho_c2_stall", {63'd0, cpuStall}, 64'd0);
    tick();
    cpuReq = 1'b0; #1;
    check_val("ho_c3_gnt", {62'd0, cpuGnt, dmaGnt}, 64'h2);
    tick();
    check_val("ho_c4_gnt", {62'd0, cpuGnt, dmaGnt}, 64'h1);
    dmaReq = 1'b0;
    tick();
    check_val("ho_c5_gnt", {62'd0, cpuGnt, dmaGnt}, 64'd0);

    // 6. reset during the second beat of a DMA write burst
    dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 32'h200; dmaWData = 32'h11111111;
    tick();
    check_val("rb_c1_we", {63'd0, memWE}, 64'd1);
    tick();
    dmaAddr = 32'h204; dmaWData = 32'h22222222; resetN = 1'b0; #1;
    check_val("rb_c2_gnt", {63'd0, dmaGnt}, 64'd1);
    check_val("rb_c2_we",  {63'd0, memWE}, 64'd0);
    tick();
    resetN = 1'b1; dmaReq = 1'b0; dmaWe = 1'b0; #1;
    check_val("rb_c3_gnt",   {62'd0, cpuGnt, dmaGnt}, 64'd0);
    check_val("rb_mem_beat1", {32'd0, mem[8'h80]}, 64'h11111111);
    check_val("rb_mem_beat2", {32'd0, mem[8'h81]}, 64'hAAAA5555);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
